// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types, keycodes and key decode for the sprite mover
package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_D = 2'd1,
        DIR_L = 2'd2,
        DIR_U = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVING  = 2'd1,
        ST_STOPPED = 2'd2,
        ST_FROZEN  = 2'd3
    } state_t;

    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_W = 8'h1A;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_dir_t;

    // Any keycode outside the four movement keys decodes as not-valid
    function automatic key_dir_t key_to_dir(input logic [7:0] key);
        key_dir_t kd;
        kd.valid = 1'b1;
        kd.dir   = DIR_R;
        case (key)
            KEY_D:   kd.dir = DIR_R;
            KEY_S:   kd.dir = DIR_D;
            KEY_A:   kd.dir = DIR_L;
            KEY_W:   kd.dir = DIR_U;
            default: kd.valid = 1'b0;
        endcase
        return kd;
    endfunction

endpackage

// File: rtl/turn_buffer.sv
// rtl/turn_buffer.sv - holds one blocked turn request until the wall opens or it times out
module turn_buffer
    import sprite_pkg::*;
#(
    parameter int TURN_HOLD = 8
)
(
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       load,
    input  dir_t       dir_in,
    input  logic [3:0] blocked,
    input  logic       clear,
    output logic       take,
    output dir_t       pending_dir,
    output logic       turn_pending
);

    localparam logic [7:0] L_HOLD = 8'(TURN_HOLD);

    dir_t       r_pending_dir;
    logic       r_turn_pending;
    logic [7:0] r_hold;

    // Clear wins over a new load; otherwise a waiting request counts down and drops at zero
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pending_dir  <= DIR_R;
            r_turn_pending <= 1'b0;
            r_hold         <= '0;
        end else if (clear) begin
            r_pending_dir  <= DIR_R;
            r_turn_pending <= 1'b0;
            r_hold         <= '0;
        end else if (load) begin
            r_pending_dir  <= dir_in;
            r_turn_pending <= 1'b1;
            r_hold         <= L_HOLD;
        end else if (r_turn_pending) begin
            if (r_hold <= 8'd1) begin
                r_turn_pending <= 1'b0;
                r_hold         <= '0;
            end else begin
                r_hold <= r_hold - 8'd1;
            end
        end
    end

    assign take         = r_turn_pending & ~blocked[r_pending_dir];
    assign pending_dir  = r_pending_dir;
    assign turn_pending = r_turn_pending;

endmodule

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - per-frame maze sprite movement with turn buffering, speed divider and wrap
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int X_CENTER  = 304,
    parameter int Y_CENTER  = 240,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int STEP      = 1,
    parameter int SPEED_DIV = 1,
    parameter int TURN_HOLD = 8,
    parameter int WRAP_X    = 1
)
(
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic [3:0] blocked,
    input  logic       freeze,
    input  logic       respawn,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [1:0] dir,
    output logic       has_moved,
    output logic       moving,
    output logic       turn_pending,
    output logic [1:0] pending_dir
);

    localparam logic [10:0] L_STEP   = 11'(STEP);
    localparam logic [10:0] L_XMIN   = 11'(X_MIN);
    localparam logic [10:0] L_XMAX   = 11'(X_MAX);
    localparam logic [10:0] L_YMIN   = 11'(Y_MIN);
    localparam logic [10:0] L_YMAX   = 11'(Y_MAX);
    localparam logic [9:0]  L_XMIN10 = 10'(X_MIN);
    localparam logic [9:0]  L_XMAX10 = 10'(X_MAX);
    localparam logic [9:0]  L_YMIN10 = 10'(Y_MIN);
    localparam logic [9:0]  L_YMAX10 = 10'(Y_MAX);
    localparam logic [9:0]  L_XCEN   = 10'(X_CENTER);
    localparam logic [9:0]  L_YCEN   = 10'(Y_CENTER);
    localparam logic [3:0]  L_DIV_LAST = 4'(SPEED_DIV - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_x;
    logic [9:0] r_y;
    dir_t       r_dir;
    logic       r_has_moved;
    logic [3:0] r_div;

    key_dir_t   w_kd;
    logic       w_run;
    logic       w_key_accept;
    logic       w_key_load;
    logic       w_take;
    logic       w_turn_take;
    logic       w_turn;
    logic       w_buf_clear;
    dir_t       w_pend_dir;
    logic       w_pend;
    dir_t       w_new_dir;
    dir_t       w_eff_dir;
    logic       w_eff_moving;
    logic       w_tick;
    logic       w_try_move;
    logic       w_wall;
    logic [10:0] w_sum;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic       w_clamp;

    turn_buffer #(
        .TURN_HOLD (TURN_HOLD)
    ) u_turn_buffer (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .load         (w_key_load),
        .dir_in       (w_kd.dir),
        .blocked      (blocked),
        .clear        (w_buf_clear),
        .take         (w_take),
        .pending_dir  (w_pend_dir),
        .turn_pending (w_pend)
    );

    // Resolve this edge's direction first so a turn and its step land on the same frame
    always_comb begin
        w_kd         = key_to_dir(keycode);
        w_run        = ~freeze & ~respawn & (r_state != ST_FROZEN);
        w_key_accept = w_run & w_kd.valid & ~blocked[w_kd.dir];
        w_key_load   = w_run & w_kd.valid & blocked[w_kd.dir];
        w_turn_take  = w_run & ~w_kd.valid & w_take;
        w_turn       = w_key_accept | w_turn_take;
        w_buf_clear  = ~w_run | w_turn;
        w_new_dir    = w_key_accept ? w_kd.dir : w_pend_dir;
        w_eff_dir    = w_turn ? w_new_dir : r_dir;
        w_eff_moving = w_turn | (r_state == ST_MOVING);
        w_tick       = (r_div == L_DIV_LAST);
        w_try_move   = w_run & w_eff_moving & w_tick;
        w_wall       = blocked[w_eff_dir];
    end

    // Candidate position one step along the resolved direction, with wrap or clamp at the edges
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        w_clamp = 1'b0;
        w_sum   = '0;
        case (w_eff_dir)
            DIR_R: begin
                w_sum = {1'b0, r_x} + L_STEP;
                if (w_sum > L_XMAX) begin
                    if (WRAP_X != 0) begin
                        w_x_nxt = L_XMIN10;
                    end else begin
                        w_x_nxt = L_XMAX10;
                        w_clamp = 1'b1;
                    end
                end else begin
                    w_x_nxt = w_sum[9:0];
                end
            end
            DIR_L: begin
                if ({1'b0, r_x} < L_XMIN + L_STEP) begin
                    if (WRAP_X != 0) begin
                        w_x_nxt = L_XMAX10;
                    end else begin
                        w_x_nxt = L_XMIN10;
                        w_clamp = 1'b1;
                    end
                end else begin
                    w_sum   = {1'b0, r_x} - L_STEP;
                    w_x_nxt = w_sum[9:0];
                end
            end
            DIR_D: begin
                w_sum = {1'b0, r_y} + L_STEP;
                if (w_sum > L_YMAX) begin
                    w_y_nxt = L_YMAX10;
                    w_clamp = 1'b1;
                end else begin
                    w_y_nxt = w_sum[9:0];
                end
            end
            default: begin
                if ({1'b0, r_y} < L_YMIN + L_STEP) begin
                    w_y_nxt = L_YMIN10;
                    w_clamp = 1'b1;
                end else begin
                    w_sum   = {1'b0, r_y} - L_STEP;
                    w_y_nxt = w_sum[9:0];
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: freeze dominates, then leaving FROZEN, then respawn, then motion outcome
    always_comb begin
        w_state_nxt = r_state;
        if (freeze) begin
            w_state_nxt = ST_FROZEN;
        end else if (r_state == ST_FROZEN) begin
            w_state_nxt = respawn ? ST_IDLE : ST_STOPPED;
        end else if (respawn) begin
            w_state_nxt = ST_IDLE;
        end else if (w_try_move && (w_wall || w_clamp)) begin
            w_state_nxt = ST_STOPPED;
        end else if (w_eff_moving) begin
            w_state_nxt = ST_MOVING;
        end
    end

    // Position, facing, first-move flag and divider; held while frozen, reloaded on respawn
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x         <= L_XCEN;
            r_y         <= L_YCEN;
            r_dir       <= DIR_R;
            r_has_moved <= 1'b0;
            r_div       <= '0;
        end else if (freeze || (r_state == ST_FROZEN && !respawn)) begin
            r_x <= r_x;
        end else if (respawn) begin
            r_x         <= L_XCEN;
            r_y         <= L_YCEN;
            r_dir       <= DIR_R;
            r_has_moved <= 1'b0;
            r_div       <= '0;
        end else begin
            if (w_turn) begin
                r_dir       <= w_new_dir;
                r_has_moved <= 1'b1;
            end
            r_div <= w_tick ? 4'd0 : r_div + 4'd1;
            if (w_try_move && !w_wall) begin
                r_x <= w_x_nxt;
                r_y <= w_y_nxt;
            end
        end
    end

    // Outputs
    always_comb begin
        pos_x        = r_x;
        pos_y        = r_y;
        dir          = r_dir;
        has_moved    = r_has_moved;
        moving       = (r_state == ST_MOVING);
        turn_pending = w_pend;
        pending_dir  = w_pend_dir;
    end

endmodule

// File: tb/tb_sprite_mover.sv
// tb/tb_sprite_mover.sv - scoreboard bench for sprite_mover against a rule-level model
module tb_sprite_mover;

    localparam int M_IDLE = 0;
    localparam int M_MOV  = 1;
    localparam int M_STOP = 2;
    localparam int M_FRZ  = 3;

    typedef struct packed {
        int x; int y; int d; int st; int pd; int hold; int div;
        bit hm; bit tp;
    } mst_t;

    typedef struct packed {
        int step; int sdiv; int thold; int wrap;
    } cfg_t;

    localparam cfg_t CFG_A = '{step: 1, sdiv: 1, thold: 8, wrap: 1};
    localparam cfg_t CFG_B = '{step: 8, sdiv: 4, thold: 3, wrap: 0};

    logic       clk;
    logic       Reset_n;
    logic [7:0] keycode;
    logic [3:0] blocked;
    logic       freeze;
    logic       respawn;

    logic [9:0] ax, ay, bx, by;
    logic [1:0] adir, bdir, apd, bpd;
    logic       ahm, bhm, amv, bmv, atp, btp;

    int n_checks = 0;
    int n_errors = 0;

    mst_t ma, mb;
    logic [26:0] qa[$];
    logic [26:0] qb[$];

    sprite_mover dut_a (
        .frame_clk(clk), .Reset_n(Reset_n), .keycode(keycode), .blocked(blocked),
        .freeze(freeze), .respawn(respawn), .pos_x(ax), .pos_y(ay), .dir(adir),
        .has_moved(ahm), .moving(amv), .turn_pending(atp), .pending_dir(apd)
    );

    sprite_mover #(.STEP(8), .SPEED_DIV(4), .TURN_HOLD(3), .WRAP_X(0)) dut_b (
        .frame_clk(clk), .Reset_n(Reset_n), .keycode(keycode), .blocked(blocked),
        .freeze(freeze), .respawn(respawn), .pos_x(bx), .pos_y(by), .dir(bdir),
        .has_moved(bhm), .moving(bmv), .turn_pending(btp), .pending_dir(bpd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [26:0] vec_a = {ax, ay, adir, ahm, amv, atp, apd};
    wire [26:0] vec_b = {bx, by, bdir, bhm, bmv, btp, bpd};

    function automatic mst_t spawn_state();
        mst_t s;
        s = '0;
        s.x = 304;
        s.y = 240;
        s.st = M_IDLE;
        return s;
    endfunction

    function automatic logic [26:0] mvec(input mst_t s);
        return {10'(s.x), 10'(s.y), 2'(s.d), s.hm, (s.st == M_MOV), s.tp, 2'(s.pd)};
    endfunction

    // One frame of the sprite rules, written directly from the priority list
    function automatic mst_t model_next(input mst_t s, input cfg_t c, input logic [7:0] key,
                                        input logic [3:0] blk, input bit frz, input bit rsp);
        mst_t n;
        bit kv, turned, tick;
        int kd, nx, ny, dx, dy;
        n = s;
        if (frz) begin
            n.st = M_FRZ; n.tp = 0; n.pd = 0; n.hold = 0;
            return n;
        end
        if (s.st == M_FRZ || rsp) begin
            if (rsp) begin
                n = spawn_state();
            end else begin
                n.st = M_STOP;
            end
            return n;
        end
        kv = 1; kd = 0;
        case (key)
            8'h07: kd = 0;
            8'h16: kd = 1;
            8'h04: kd = 2;
            8'h1A: kd = 3;
            default: kv = 0;
        endcase
        turned = 0;
        if (kv) begin
            if (!blk[kd]) begin
                n.d = kd; turned = 1;
            end else begin
                n.tp = 1; n.pd = kd; n.hold = c.thold;
            end
        end else if (s.tp) begin
            if (!blk[s.pd]) begin
                n.d = s.pd; turned = 1;
            end else begin
                n.hold = s.hold - 1;
                if (n.hold == 0) n.tp = 0;
            end
        end
        if (turned) begin
            n.hm = 1; n.st = M_MOV; n.tp = 0; n.pd = 0; n.hold = 0;
        end
        tick = (s.div == c.sdiv - 1);
        n.div = tick ? 0 : s.div + 1;
        if (tick && n.st == M_MOV) begin
            if (blk[n.d]) begin
                n.st = M_STOP;
            end else begin
                dx = (n.d == 0) ? 1 : (n.d == 2) ? -1 : 0;
                dy = (n.d == 1) ? 1 : (n.d == 3) ? -1 : 0;
                nx = s.x + dx * c.step;
                ny = s.y + dy * c.step;
                if (ny < 0)   begin ny = 0;   n.st = M_STOP; end
                if (ny > 479) begin ny = 479; n.st = M_STOP; end
                if (nx > 639) begin
                    if (c.wrap != 0) nx = 0;
                    else begin nx = 639; n.st = M_STOP; end
                end
                if (nx < 0) begin
                    if (c.wrap != 0) nx = 639;
                    else begin nx = 0; n.st = M_STOP; end
                end
                n.x = nx;
                n.y = ny;
            end
        end
        return n;
    endfunction

    task automatic check(input string nm, input logic [26:0] act, input logic [26:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got x=%0d y=%0d dir=%0d hm=%0b mv=%0b tp=%0b pd=%0d want x=%0d y=%0d dir=%0d hm=%0b mv=%0b tp=%0b pd=%0d",
                     nm, $time, act[26:17], act[16:7], act[6:5], act[4], act[3], act[2], act[1:0],
                     exp[26:17], exp[16:7], exp[6:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic drive(input logic [7:0] k, input logic [3:0] b, input bit f, input bit r);
        @(negedge clk);
        keycode = k; blocked = b; freeze = f; respawn = r;
        ma = model_next(ma, CFG_A, k, b, f, r);
        mb = model_next(mb, CFG_B, k, b, f, r);
        qa.push_back(mvec(ma));
        qb.push_back(mvec(mb));
    endtask

    // Asynchronous reset pulse mid-frame, checked immediately, then the following edge is scored
    task automatic do_reset();
        @(negedge clk);
        keycode = 8'h00; blocked = 4'h0; freeze = 1'b0; respawn = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("async_reset_a", vec_a, mvec(spawn_state()));
        check("async_reset_b", vec_b, mvec(spawn_state()));
        #1;
        Reset_n = 1'b1;
        ma = model_next(spawn_state(), CFG_A, 8'h00, 4'h0, 0, 0);
        mb = model_next(spawn_state(), CFG_B, 8'h00, 4'h0, 0, 0);
        qa.push_back(mvec(ma));
        qb.push_back(mvec(mb));
    endtask

    // Monitor: every frame edge presents a new output set, scored against the queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) check("frame_a", vec_a, qa.pop_front());
            if (qb.size() > 0) check("frame_b", vec_b, qb.pop_front());
        end
    end

    initial begin
        Reset_n = 1'b0;
        keycode = 8'h00; blocked = 4'h0; freeze = 1'b0; respawn = 1'b0;
        ma = spawn_state();
        mb = spawn_state();
        repeat (2) @(negedge clk);
        do_reset();

        repeat (3) drive(8'h07, 4'h0, 0, 0);
        drive(8'h16, 4'b0010, 0, 0);
        repeat (3) drive(8'h00, 4'b0010, 0, 0);
        repeat (3) drive(8'h00, 4'h0, 0, 0);
        drive(8'h1A, 4'b1000, 0, 0);
        repeat (10) drive(8'h00, 4'b1000, 0, 0);
        repeat (4) drive(8'h00, 4'b0010, 0, 0);
        repeat (2) drive(8'h00, 4'h0, 0, 0);

        drive(8'h07, 4'h0, 0, 0);
        repeat (400) drive(8'h00, 4'h0, 0, 0);
        drive(8'h1A, 4'h0, 0, 0);
        repeat (300) drive(8'h00, 4'h0, 0, 0);
        drive(8'h04, 4'h0, 0, 0);
        repeat (400) drive(8'h00, 4'h0, 0, 0);

        drive(8'h16, 4'h0, 0, 0);
        repeat (6) drive(8'h00, 4'h0, 0, 0);
        repeat (3) drive(8'h07, 4'h0, 1, 1);
        drive(8'h00, 4'h0, 0, 1);
        repeat (2) drive(8'h00, 4'h0, 0, 0);
        drive(8'h07, 4'h0, 0, 0);
        repeat (2) drive(8'h16, 4'h0, 1, 0);
        repeat (3) drive(8'h00, 4'h0, 0, 0);

        drive(8'h07, 4'h0, 0, 0);
        repeat (5) drive(8'h00, 4'h0, 0, 0);
        do_reset();

        for (int i = 0; i < 2000; i++) begin
            logic [7:0] k;
            logic [3:0] b;
            bit f, r;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 9))
                    0: k = 8'h07;
                    1: k = 8'h16;
                    2: k = 8'h04;
                    3: k = 8'h1A;
                    4: k = 8'($urandom);
                    default: k = 8'h00;
                endcase
                b = 4'($urandom & $urandom);
                f = ($urandom_range(0, 24) == 0);
                r = ($urandom_range(0, 29) == 0);
                drive(k, b, f, r);
            end
        end

        repeat (2) @(negedge clk);
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
